// File: rtl/mcp3_req_queue008_pkg.sv
// Shared constants, types and helpers for the 8-source request queue front end.
package mcp3_req_queue008_pkg;

    localparam int MCP3_NUM_SRC  = 8;
    localparam int MCP3_SRC_ID_W = 3;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } fifo_cnt_e;

    // True when no more than one bit of v is set.
    function automatic logic onehot0(input logic [MCP3_NUM_SRC-1:0] v);
        return (v & (v - MCP3_NUM_SRC'(1))) == {MCP3_NUM_SRC{1'b0}};
    endfunction

endpackage

// File: rtl/mcp3_req_queue008_fifo2.sv
// Two-entry in-order command queue for one source: head in slot0, tail in slot1.
module mcp3_req_fifo2
    import mcp3_req_queue008_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  ready,
    output logic                  nonempty,
    output logic                  full,
    output logic                  underflow,
    output logic [DATA_WIDTH-1:0] head
);

    fifo_cnt_e             count_q, count_d;
    logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
    logic                  push_s;
    logic                  pop_s;

    // Next-state computation for occupancy and payload slots.
    always_comb begin
        push_s  = push_valid & ready;
        pop_s   = pop & nonempty;
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push_s, pop_s})
            2'b10: begin
                case (count_q)
                    CNT_EMPTY: begin
                        slot0_d = push_data;
                        count_d = CNT_ONE;
                    end
                    CNT_ONE: begin
                        slot1_d = push_data;
                        count_d = CNT_FULL;
                    end
                    default: count_d = count_q;
                endcase
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = (count_q == CNT_FULL) ? CNT_ONE : CNT_EMPTY;
            end
            // Push and pop together only happen at one entry: new data becomes head.
            2'b11: begin
                slot0_d = push_data;
                count_d = count_q;
            end
            default: count_d = count_q;
        endcase
    end

    // Occupancy register; reset empties the queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= CNT_EMPTY;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage, deliberately not reset.
    always_ff @(posedge clock) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    // Status flags derived from registered occupancy only.
    always_comb begin
        ready     = (count_q == CNT_EMPTY) | (count_q == CNT_ONE);
        nonempty  = (count_q == CNT_ONE) | (count_q == CNT_FULL);
        full      = (count_q == CNT_FULL);
        underflow = pop & (count_q == CNT_EMPTY);
        head      = slot0_q;
    end

endmodule

// File: rtl/mcp3_req_queue008.sv
// Requestor front end of the 8-way round-robin arbiter: per-source queues, winner mux,
// downstream handshake and sticky protocol-error detection on req_clear.
module mcp3_req_queue008
    import mcp3_req_queue008_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [MCP3_NUM_SRC-1:0]              src_valid,
    input  logic [MCP3_NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [MCP3_NUM_SRC-1:0]              src_ready,
    output logic [MCP3_NUM_SRC-1:0]              req_bus,
    output logic [MCP3_NUM_SRC-1:0]              req_bus_2pending,
    input  logic                                 winner_valid,
    input  logic [MCP3_SRC_ID_W-1:0]             winner,
    input  logic [MCP3_NUM_SRC-1:0]              req_clear,
    output logic                                 req_taken,
    output logic                                 out_valid,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [MCP3_SRC_ID_W-1:0]             out_src,
    input  logic                                 out_ready,
    output logic                                 err_clear
);

    logic [MCP3_NUM_SRC-1:0] pop_s;
    logic [MCP3_NUM_SRC-1:0] underflow_s;
    logic [DATA_WIDTH-1:0]   head_s [MCP3_NUM_SRC];
    logic                    clr_multi_s;
    logic                    clr_untaken_s;
    logic                    clr_legal_s;
    logic                    err_clear_d;
    logic                    err_clear_q;

    for (genvar gi = 0; gi < MCP3_NUM_SRC; gi++) begin : g_src
        mcp3_req_fifo2 #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clock      (clock),
            .reset_n    (reset_n),
            .push_valid (src_valid[gi]),
            .push_data  (src_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .pop        (pop_s[gi]),
            .ready      (src_ready[gi]),
            .nonempty   (req_bus[gi]),
            .full       (req_bus_2pending[gi]),
            .underflow  (underflow_s[gi]),
            .head       (head_s[gi])
        );
    end

    // Winner mux, handshake, and pop gating: a malformed req_clear pops nothing.
    always_comb begin
        out_valid     = winner_valid & req_bus[winner];
        out_data      = head_s[winner];
        out_src       = winner;
        req_taken     = out_valid & out_ready;
        clr_multi_s   = ~onehot0(req_clear);
        clr_untaken_s = (req_clear != {MCP3_NUM_SRC{1'b0}}) & ~req_taken;
        clr_legal_s   = ~clr_multi_s & ~clr_untaken_s;
        pop_s         = clr_legal_s ? req_clear : {MCP3_NUM_SRC{1'b0}};
        err_clear_d   = err_clear_q | clr_multi_s | clr_untaken_s
                        | ((req_clear & ~req_bus) != {MCP3_NUM_SRC{1'b0}})
                        | (underflow_s != {MCP3_NUM_SRC{1'b0}});
        err_clear     = err_clear_q;
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_clear_q <= 1'b0;
        end else begin
            err_clear_q <= err_clear_d;
        end
    end

endmodule

// File: tb/tb_mcp3_req_queue008.sv
// Directed plus randomized bench for mcp3_req_queue008 against a queue-based reference model.
module tb_mcp3_req_queue008;
    import mcp3_req_queue008_pkg::*;

    localparam int DW = 64;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [7:0]     src_valid = 8'h00;
    logic [8*DW-1:0] src_data = '0;
    logic [7:0]     src_ready, req_bus, req_bus_2pending;
    logic           winner_valid = 1'b0;
    logic [2:0]     winner = 3'd0;
    logic [7:0]     req_clear = 8'h00;
    logic           req_taken, out_valid, out_ready = 1'b0, err_clear;
    logic [DW-1:0]  out_data;
    logic [2:0]     out_src;

    logic [DW-1:0]  mq [8][$];
    bit             exp_err = 1'b0;
    bit             auto_clr = 1'b1;
    int             n_vec = 0;
    int             n_err = 0;

    mcp3_req_queue008 #(.DATA_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .req_bus(req_bus), .req_bus_2pending(req_bus_2pending),
        .winner_valid(winner_valid), .winner(winner), .req_clear(req_clear),
        .req_taken(req_taken), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready), .err_clear(err_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int s, input logic [DW-1:0] d);
        src_data[s*DW +: DW] = d;
    endtask

    // One clock: predict, check at negedge, advance the model at posedge.
    task automatic cycle();
        logic [7:0] eb, e2, er, chg;
        logic       ev, taken, multi, legal;
        int         w;
        w = int'(winner);
        for (int i = 0; i < 8; i++) begin
            eb[i] = (mq[i].size() != 0);
            e2[i] = (mq[i].size() == 2);
            er[i] = (mq[i].size() < 2);
        end
        ev = winner_valid & eb[w];
        if (auto_clr) req_clear = (ev && out_ready) ? (8'd1 << w) : 8'h00;
        @(negedge clock);
        chk("req_bus", DW'(req_bus), DW'(eb));
        chk("req_bus_2pending", DW'(req_bus_2pending), DW'(e2));
        chk("src_ready", DW'(src_ready), DW'(er));
        chk("out_valid", DW'(out_valid), DW'(ev));
        chk("req_taken", DW'(req_taken), DW'(ev & out_ready));
        chk("out_src", DW'(out_src), DW'(w));
        chk("err_clear", DW'(err_clear), DW'(exp_err));
        if (ev) chk("out_data", out_data, mq[w][0]);
        @(posedge clock);
        taken = ev & out_ready;
        chg   = req_clear;
        multi = ($countones(chg) > 1);
        legal = !multi && (chg == 8'h00 || taken);
        if (multi || (chg != 8'h00 && !taken)) exp_err = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (chg[i] && mq[i].size() == 0) exp_err = 1'b1;
            if (legal && chg[i] && mq[i].size() != 0) void'(mq[i].pop_front());
            if (src_valid[i] && er[i]) mq[i].push_back(src_data[i*DW +: DW]);
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mq[i].delete();
        exp_err = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_req_bus", DW'(req_bus), DW'(8'h00));
        chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
        chk("rst_err_clear", DW'(err_clear), DW'(1'b0));
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset and idle
        winner_valid = 1'b1;
        out_ready = 1'b1;
        #3;
        chk("por_req_bus", DW'(req_bus), DW'(8'h00));
        chk("por_req_bus_2pending", DW'(req_bus_2pending), DW'(8'h00));
        chk("por_out_valid", DW'(out_valid), DW'(1'b0));
        chk("por_req_taken", DW'(req_taken), DW'(1'b0));
        chk("por_err_clear", DW'(err_clear), DW'(1'b0));
        #9;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        winner_valid = 1'b0;
        out_ready = 1'b0;
        cycle();
        chk("idle_src_ready", DW'(src_ready), DW'(8'hFF));

        // Single push on source 3, then taken and popped
        src_valid = 8'h08; set_src(3, 64'hA5);
        cycle();
        src_valid = 8'h00;
        winner = 3'd3; winner_valid = 1'b1; out_ready = 1'b1;
        chk("push3_req_bus", DW'(req_bus), DW'(8'h08));
        cycle();
        winner_valid = 1'b0;
        cycle();

        // Source 5 fills, third push refused, pop exposes second entry
        src_valid = 8'h20; set_src(5, 64'h11); cycle();
        set_src(5, 64'h22); cycle();
        set_src(5, 64'h99); cycle();
        src_valid = 8'h00;
        winner = 3'd5; winner_valid = 1'b1; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        chk("src5_head", out_data, 64'h22);
        out_ready = 1'b1;
        cycle();
        winner_valid = 1'b0;

        // Source 2 push and pop in the same cycle
        src_valid = 8'h04; set_src(2, 64'h33); cycle();
        set_src(2, 64'h44);
        winner = 3'd2; winner_valid = 1'b1; out_ready = 1'b1;
        cycle();
        src_valid = 8'h00; out_ready = 1'b0;
        cycle();
        chk("src2_head", out_data, 64'h44);
        out_ready = 1'b1;
        cycle();
        winner_valid = 1'b0;

        // Backpressure on source 1
        src_valid = 8'h02; set_src(1, 64'h5555_0000_1234_ABCD); cycle();
        src_valid = 8'h00;
        winner = 3'd1; winner_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        winner_valid = 1'b0;

        // Protocol errors
        auto_clr = 1'b0;
        req_clear = 8'h01; cycle();
        req_clear = 8'h00; cycle(); cycle();
        async_reset();
        src_valid = 8'h02; set_src(1, 64'h77); cycle();
        src_valid = 8'h00;
        req_clear = 8'h06; cycle();
        req_clear = 8'h00; cycle();
        async_reset();
        src_valid = 8'h08; set_src(3, 64'h88); cycle();
        src_valid = 8'h00;
        req_clear = 8'h08; cycle();
        req_clear = 8'h00; cycle(); cycle();
        async_reset();
        cycle();

        // Randomized traffic with a well-behaved arbiter
        auto_clr = 1'b1;
        for (int k = 0; k < 400; k++) begin
            src_valid = 8'($urandom);
            for (int i = 0; i < 8; i++) set_src(i, {$urandom, $urandom});
            winner_valid = 1'($urandom_range(0, 3) != 0);
            winner = 3'($urandom);
            out_ready = 1'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mcp3_req_queue008.md
Name: mcp3_req_queue008

Overview:
- Requestor-side front end of the 8-way round-robin arbiter.
- Holds up to two pending commands per source in a 2-deep queue per source.
- Drives the arbiter's req_bus / req_bus_2pending inputs from queue occupancy.
- Consumes the arbiter's winner / winner_valid, presents the winning head command downstream with a valid/ready handshake, returns req_taken to the arbiter, and pops the queue named by the arbiter's req_clear.

Parameters:
- DATA_WIDTH, 64, width of one command payload per source.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- src_valid  in  8  per-source command valid.
- src_data  in  8*DATA_WIDTH  per-source payload; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_ready  out  8  per-source accept.
- req_bus  out  8  to arbiter; bit i = source i has at least 1 entry.
- req_bus_2pending  out  8  to arbiter; bit i = source i has 2 entries.
- winner_valid  in  1  from arbiter.
- winner  in  3  from arbiter, encoded winning source.
- req_clear  in  8  from arbiter, one-hot pop of the taken source.
- req_taken  out  1  to arbiter; winning command accepted downstream this cycle.
- out_valid  out  1  downstream command valid.
- out_data  out  DATA_WIDTH  downstream payload (head of the winning queue).
- out_src  out  3  downstream source id (equals winner).
- out_ready  in  1  downstream accept.
- err_clear  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all counts 0, so req_bus = 0 and req_bus_2pending = 0;
  - src_ready = 8'hFF once reset deasserts;
  - err_clear = 0; payload storage is not reset.
- Reset asserted mid-operation drops every queued entry immediately. out_valid and req_taken are 0 while reset_n is low.
- Per-source state:
  - count[i] in {0, 1, 2}, plus slot0 (head) and slot1 (tail).
  - req_bus[i] = (count != 0) and req_bus_2pending[i] = (count == 2); both registered-state derived, no combinational path from src_valid.
- Push:
  - src_ready[i] = (count < 2), derived from registered state only. There is no bypass when full, even if a pop occurs in the same cycle.
  - push_i = src_valid[i] & src_ready[i].
  - count 0: write slot0. count 1: write slot1.
- Pop: pop_i = req_clear[i].
  - Moves slot1 to slot0 and decrements count.
- Simultaneous push and pop:
  - count 1 → count stays 1, new data written to slot0.
  - count 2 → cannot occur (src_ready = 0).
- Output side (combinational, all from registered state plus out_ready):
  - out_valid = winner_valid & req_bus[winner].
  - out_data = slot0[winner]; out_src = winner.
  - req_taken = out_valid & out_ready.
- Handshake rules:
  - The arbiter returns req_clear = one-hot(winner) in the same cycle as req_taken; the pop takes effect at the next edge.
  - One command moves downstream per cycle at most.
  - Zero-cycle latency from winner to out_valid; one cycle from push to req_bus.
  - out_data must stay stable while out_valid = 1 and out_ready = 0. Guaranteed because the arbiter holds its winner until req_taken, and the head changes only on pop.
- Error detection (err_clear set, sticky until reset):
  - req_clear has more than one bit set;
  - req_clear[i] with count[i] == 0 (underflow; the pop is ignored and count stays 0);
  - req_clear != 0 while req_taken == 0.
- Wrap-around and fairness are owned entirely by the arbiter. This block never reorders entries within a source.

Decomposition:
- Shared package constants: MCP3_NUM_SRC = 8, MCP3_SRC_ID_W = 3.
- One sub-module, mcp3_req_fifo2: 2-entry queue with count, push/pop, ready, nonempty/full and underflow outputs.
  - Instantiated 8 times via generate.
  - The top level holds the output mux, the handshake logic and the error OR.

Test Plan:
- Reset then idle → req_bus = 0, src_ready = 8'hFF, out_valid = 0, err_clear = 0; async assert mid-cycle clears counts before the next edge.
- Push source 3 data 0xA5 (one cycle) → next cycle req_bus = 8'h08. With winner = 3, winner_valid = 1, out_ready = 1 → out_valid = 1, out_data = 0xA5, out_src = 3, req_taken = 1. Drive req_clear = 8'h08 → req_bus = 0 next cycle.
- Push source 5 values 0x11 then 0x22 → req_bus_2pending = 8'h20, src_ready[5] = 0. A third push is not accepted. Pop → out_data becomes 0x22, src_ready[5] = 1.
- Source 2 at count 1 (0x33): same-cycle push 0x44 and req_clear = 8'h04 → count stays 1, head = 0x44, req_bus[2] = 1.
- Backpressure: winner = 1 valid, out_ready = 0 for 5 cycles → out_valid held 1, out_data stable, req_taken = 0. out_ready = 1 → single req_taken pulse.
- Protocol errors, each leaving the affected count unchanged:
  - req_clear = 8'h01 with source 0 empty → err_clear = 1 and stays 1;
  - req_clear = 8'h06 → err_clear = 1;
  - req_clear = 8'h08 with req_taken = 0 → err_clear = 1.
  - Reset → err_clear = 0.
